// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Combinational EX operand forwarding plus a small FSM that sequences
// load-use bubbles, branch flushes and multi-cycle execute stalls.
// Stall/flush outputs are decoded combinationally from the current state and
// inputs; only StallCount is registered.
// Handshake: a multi-cycle op presents MCStartE for its first EX cycle and the
// pipeline stays stalled until the cycle in which MCDone is seen high
// (inclusive); MCDone in the MCStartE cycle completes with no stall.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RS1D,
  input  logic [REG_AW-1:0] RS2D,
  input  logic [REG_AW-1:0] RS1E,
  input  logic [REG_AW-1:0] RS2E,
  input  logic [REG_AW-1:0] RDE,
  input  logic [REG_AW-1:0] RDM,
  input  logic [REG_AW-1:0] RDW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReadE,
  input  logic              PCSrcE,
  input  logic              MCStartE,
  input  logic              MCDone,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [CNT_W-1:0]  StallCount,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDSTALL = 2'd1,
    S_MCWAIT  = 2'd2
  } state_t;

  // Bubbles still owed after the detecting cycle.
  localparam logic [2:0] LCNT_INIT = 3'(LOAD_LAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_lcnt;
  logic [2:0]  w_next_lcnt;
  logic        w_load_use;
  logic        w_stall_f, w_stall_d, w_stall_e;
  logic        w_flush_d, w_flush_e, w_flush_m;
  logic [1:0]  w_fwd_a, w_fwd_b;

  assign w_load_use = MemReadE && (RDE != '0) && ((RDE == RS1D) || (RDE == RS2D));

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && (RDM != '0) && (RDM == rs))      fwd_sel = 2'b10;
    else if (RegWriteW && (RDW != '0) && (RDW == rs)) fwd_sel = 2'b01;
    else                                              fwd_sel = 2'b00;
  endfunction

  // Forwarding selects, MEM result preferred over WB result.
  always_comb begin
    w_fwd_a = fwd_sel(RS1E);
    w_fwd_b = fwd_sel(RS2E);
  end

  // Next-state and stall/flush decode.
  always_comb begin
    w_next_state = r_state;
    w_next_lcnt  = r_lcnt;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_flush_m    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (PCSrcE) begin
          // Taken branch squashes decode and execute; the wrong-path
          // hazards it would have raised no longer matter.
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (MCStartE) begin
          if (!MCDone) begin
            w_stall_f    = 1'b1;
            w_stall_d    = 1'b1;
            w_stall_e    = 1'b1;
            w_flush_m    = 1'b1;
            w_next_state = S_MCWAIT;
          end
        end else if (w_load_use) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
          if (LOAD_LAT > 1) begin
            w_next_state = S_LDSTALL;
            w_next_lcnt  = LCNT_INIT;
          end
        end
      end
      S_LDSTALL: begin
        w_stall_f   = 1'b1;
        w_stall_d   = 1'b1;
        w_flush_e   = 1'b1;
        w_next_lcnt = r_lcnt - 3'd1;
        if (r_lcnt == 3'd1) w_next_state = S_RUN;
      end
      S_MCWAIT: begin
        // Branches are ignored here: the branch instruction is frozen in EX.
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_flush_m = 1'b1;
        if (MCDone) w_next_state = S_RUN;
      end
      default: begin
        w_next_state = S_RUN;
        w_next_lcnt  = 3'd0;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, without waiting for a clock.
  always_comb begin
    ForwardAE = rst ? w_fwd_a : 2'b00;
    ForwardBE = rst ? w_fwd_b : 2'b00;
    StallF    = rst & w_stall_f;
    StallD    = rst & w_stall_d;
    StallE    = rst & w_stall_e;
    FlushD    = rst & w_flush_d;
    FlushE    = rst & w_flush_e;
    FlushM    = rst & w_flush_m;
  end

  assign o_dbg_state = r_state;

  // FSM state and load-bubble counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_lcnt  <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_lcnt  <= w_next_lcnt;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != '1)) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share stimulus and are checked against a cycle-level
// behavioural model of the hazard rules.
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
  logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, MCStartE, MCDone;

  logic [1:0]  fa1, fb1, fa3, fb3, dbg1, dbg3;
  logic        sf1, sd1, se1, fd1, fe1, fm1;
  logic        sf3, sd3, se3, fd3, fe3, fm3;
  logic [15:0] cnt1;
  logic [3:0]  cnt3;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .RDM(RDM), .RDW(RDW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MCStartE(MCStartE), .MCDone(MCDone),
    .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .FlushM(fm1), .StallCount(cnt1), .o_dbg_state(dbg1)
  );

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .RDM(RDM), .RDW(RDW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MCStartE(MCStartE), .MCDone(MCDone),
    .ForwardAE(fa3), .ForwardBE(fb3), .StallF(sf3), .StallD(sd3), .StallE(se3),
    .FlushD(fd3), .FlushE(fe3), .FlushM(fm3), .StallCount(cnt3), .o_dbg_state(dbg3)
  );

  logic [9:0] act1, act3;
  assign act1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, fm1};
  assign act3 = {fa3, fb3, sf3, sd3, se3, fd3, fe3, fm3};

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", tag, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: bubbles still owed by a load, whether a multi-cycle op is
  // outstanding, and the expected stall-cycle count.
  int lat[2]  = '{1, 3};
  int cmax[2] = '{65535, 15};
  int m_ld[2];
  bit m_mc[2];
  int m_cnt[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ld[k] = 0; m_mc[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RDM != 0 && RDM == rs)      return 2'b10;
    else if (RegWriteW && RDW != 0 && RDW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit load_use();
    return MemReadE && RDE != 0 && (RDE == RS1D || RDE == RS2D);
  endfunction

  // Expected {FwdA, FwdB, StallF, StallD, StallE, FlushD, FlushE, FlushM}.
  function automatic logic [9:0] exp_out(input int k);
    logic sf, sd, se, fd, fe, fm;
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0; fm = 0;
    if (!rst) return 10'd0;
    if (m_mc[k]) begin
      sf = 1; sd = 1; se = 1; fm = 1;
    end else if (m_ld[k] > 0) begin
      sf = 1; sd = 1; fe = 1;
    end else if (PCSrcE) begin
      fd = 1; fe = 1;
    end else if (MCStartE) begin
      if (!MCDone) begin sf = 1; sd = 1; se = 1; fm = 1; end
    end else if (load_use()) begin
      sf = 1; sd = 1; fe = 1;
    end
    return {fwd(RS1E), fwd(RS2E), sf, sd, se, fd, fe, fm};
  endfunction

  task automatic model_clock(input int k);
    logic [9:0] e;
    e = exp_out(k);
    if (!rst) begin
      m_ld[k] = 0; m_mc[k] = 1'b0; m_cnt[k] = 0;
      return;
    end
    if (m_mc[k])           m_mc[k] = !MCDone;
    else if (m_ld[k] > 0)  m_ld[k] = m_ld[k] - 1;
    else if (!PCSrcE) begin
      if (MCStartE)        m_mc[k] = !MCDone;
      else if (load_use()) m_ld[k] = lat[k] - 1;
    end
    if (e[5] && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    RS1D = 0; RS2D = 0; RS1E = 0; RS2E = 0; RDE = 0; RDM = 0; RDW = 0;
    RegWriteM = 0; RegWriteW = 0; MemReadE = 0; PCSrcE = 0; MCStartE = 0; MCDone = 0;
  endtask

  task automatic rand_in();
    RS1D = 5'($urandom_range(0, 3)); RS2D = 5'($urandom_range(0, 3));
    RS1E = 5'($urandom_range(0, 3)); RS2E = 5'($urandom_range(0, 3));
    RDE  = 5'($urandom_range(0, 3)); RDM  = 5'($urandom_range(0, 3));
    RDW  = 5'($urandom_range(0, 3));
    RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
    MemReadE  = ($urandom_range(0, 2) == 0);
    PCSrcE    = ($urandom_range(0, 7) == 0);
    MCStartE  = ($urandom_range(0, 9) == 0);
    MCDone    = ($urandom_range(0, 2) == 0);
  endtask

  task automatic check_outputs();
    chk("out_lat1", 32'(act1), 32'(exp_out(0)));
    chk("out_lat3", 32'(act3), 32'(exp_out(1)));
  endtask

  task automatic check_counts();
    chk("cnt_lat1", 32'(cnt1), 32'(m_cnt[0]));
    chk("cnt_lat3", 32'(cnt3), 32'(m_cnt[1]));
  endtask

  // Called just after a falling edge with inputs driven: check the
  // combinational outputs, advance one clock, check the counters.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_clock(0);
    model_clock(1);
    #1 check_counts();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int mc_stall_cycles;

  initial begin
    clear_in();
    model_reset();
    // Reset state
    #2;
    check_outputs();
    check_counts();
    chk("rst_state_lat1", 32'(dbg1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Forwarding priority
    RS1E = 5; RDM = 5; RegWriteM = 1; RDW = 5; RegWriteW = 1;
    #1 chk("fwd_mem", 32'(fa1), 32'b10);
    step();
    RegWriteM = 0;
    #1 chk("fwd_wb", 32'(fa1), 32'b01);
    step();
    RDM = 0; RDW = 0; RS1E = 0; RegWriteM = 1;
    #1 chk("fwd_none", 32'(fa1), 32'b00);
    step();

    // Load-use hazard, detected for one cycle, then the bubble drains
    clear_in();
    MemReadE = 1; RDE = 7; RS2D = 7;
    step();
    clear_in();
    for (int i = 0; i < 4; i++) step();
    chk("ld_cnt_lat1", 32'(cnt1), 32'd1);
    chk("ld_cnt_lat3", 32'(cnt3), 32'd3);

    // Load to x0 is never a hazard
    MemReadE = 1; RDE = 0; RS1D = 0; RS2D = 0;
    #1 chk("ld_x0_nostall", 32'(sf3), 32'd0);
    step();

    // Branch beats load-use
    MemReadE = 1; RDE = 7; RS1D = 7; PCSrcE = 1;
    #1 chk("br_flushd", 32'(fd3), 32'd1);
    chk("br_nostall", 32'(sf3), 32'd0);
    step();
    clear_in();
    step();

    // Multi-cycle op: done 4 cycles after start, branch pulsed mid-wait
    mc_stall_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      clear_in();
      MCStartE = (i == 0);
      MCDone   = (i == 4);
      PCSrcE   = (i == 2);
      #1 if (sf1 && sd1 && se1 && fm1) mc_stall_cycles++;
      step();
    end
    chk("mc_stall_len", 32'(mc_stall_cycles), 32'd5);

    // MCDone in the start cycle: zero stall
    MCStartE = 1; MCDone = 1;
    #1 chk("mc_instant", 32'(sf1), 32'd0);
    step();
    clear_in();

    // Async reset during LDSTALL (lat3 instance, lcnt=2)
    MemReadE = 1; RDE = 3; RS1D = 3;
    step();
    clear_in();
    #1 chk("in_ldstall", 32'(dbg3), 32'd1);
    #1 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    check_counts();
    @(negedge clk);
    rst = 1'b1;
    step();

    // Async reset during MCWAIT
    MCStartE = 1;
    step();
    clear_in();
    #1 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    check_counts();
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_state_run", 32'(dbg1), 32'd0);
    step();

    // Long multi-cycle wait saturates the 4-bit counter
    MCStartE = 1;
    step();
    clear_in();
    for (int i = 0; i < 18; i++) step();
    MCDone = 1;
    step();
    clear_in();
    step();
    chk("cnt_sat", 32'(cnt3), 32'd15);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      rst = ($urandom_range(0, 199) != 0);
      step();
      rst = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
